// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and master FSM state encodings.
package axi_lite_pkg;

    typedef logic [11:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RADDR      = 3'd1;
    localparam logic [2:0] ST_RDATA      = 3'd2;
    localparam logic [2:0] ST_WADDR_DATA = 3'd3;
    localparam logic [2:0] ST_WRESP      = 3'd4;
    localparam logic [2:0] ST_RSP        = 3'd5;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out,
// one response back carrying data, response code and saturating latency.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int LAT_W = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  addr_t            cmd_addr,
    input  data_t            cmd_wdata,
    input  strb_t            cmd_wstrb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output data_t            rsp_rdata,
    output resp_t            rsp_resp,
    output logic [LAT_W-1:0] rsp_latency,
    output addr_t            awaddr,
    output logic             awvalid,
    input  logic             awready,
    output data_t            wdata,
    output strb_t            wstrb,
    output logic             wvalid,
    input  logic             wready,
    input  resp_t            bresp,
    input  logic             bvalid,
    output logic             bready,
    output addr_t            araddr,
    output logic             arvalid,
    input  logic             arready,
    input  data_t            rdata,
    input  resp_t            rresp,
    input  logic             rvalid,
    output logic             rready
);

    logic [2:0]       state_q, state_d;
    addr_t            addr_q, addr_d;
    data_t            wdata_q, wdata_d;
    strb_t            wstrb_q, wstrb_d;
    logic             write_q, write_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    data_t            rdata_q, rdata_d;
    resp_t            resp_q, resp_d;
    logic [LAT_W-1:0] lat_q, lat_d, lat_inc;

    // Every handshake below is gated by a state-only valid/ready, so none feeds back.
    assign cmd_ready = (state_q == ST_IDLE) && !areset;
    assign arvalid   = (state_q == ST_RADDR);
    assign rready    = (state_q == ST_RDATA);
    assign awvalid   = (state_q == ST_WADDR_DATA) && !aw_done_q;
    assign wvalid    = (state_q == ST_WADDR_DATA) && !w_done_q;
    assign bready    = (state_q == ST_WRESP);
    assign rsp_valid = (state_q == ST_RSP);

    assign awaddr      = addr_q;
    assign araddr      = addr_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_latency = lat_q;

    logic cmd_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_fin, w_fin;
    assign cmd_hs = cmd_valid && cmd_ready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q || w_hs;

    assign lat_inc = (&lat_q) ? lat_q : lat_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        lat_d     = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    lat_d     = '0;
                    state_d   = cmd_write ? ST_WADDR_DATA : ST_RADDR;
                end
            end
            ST_RADDR: begin
                lat_d = lat_inc;
                if (ar_hs) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                lat_d = lat_inc;
                if (r_hs) begin
                    rdata_d = rdata;
                    resp_d  = rresp;
                    state_d = ST_RSP;
                end
            end
            ST_WADDR_DATA: begin
                lat_d     = lat_inc;
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WRESP;
                end
            end
            ST_WRESP: begin
                lat_d = lat_inc;
                if (b_hs) begin
                    rdata_d = '0;
                    resp_d  = bresp;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            lat_q     <= lat_d;
        end
    end

endmodule
